// File: rtl/coin_decoder.sv
// Coin-bus receiver: debounces 2-bit coin codes, pulses the accepted denomination, and keeps saturating credit.
// Optional build macro COIN_TALLY_EN adds per-denomination accepted-coin tallies (tally_p/h/f).
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | bus quiet, waiting for a nonzero code
//  QUAL     | nonzero code latched, counting consecutive matching cycles
//  ACCEPT   | one cycle: denomination pulses high, credit updates on exit
//  WAIT_REL | coin counted, waiting for the bus to return to 00
module coin_decoder #(
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 255,
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          code,
  input  logic                clear,
  output logic                coin_p,
  output logic                coin_h,
  output logic                coin_f,
  output logic                coin_valid,
  output logic [CREDIT_W-1:0] credit,
  output logic                overflow
`ifdef COIN_TALLY_EN
  ,
  output logic [7:0]          tally_p,
  output logic [7:0]          tally_h,
  output logic [7:0]          tally_f
`endif
);

  localparam int CNT_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CREDIT_W:0] MAX_EXT  = (CREDIT_W + 1)'(MAX_CREDIT);

  typedef enum logic [1:0] {IDLE, QUAL, ACCEPT, WAIT_REL} state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_code, w_code_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_coin_p, r_coin_h, r_coin_f;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic                w_accept;
  logic                w_enter_accept;
  logic [CREDIT_W:0]   w_coin_val;
  logic [CREDIT_W:0]   w_base;
  logic [CREDIT_W:0]   w_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_code  <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (code != 2'b00) begin
          w_code_nxt  = code;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = (DEBOUNCE_CYC == 1) ? ACCEPT : QUAL;
        end
      end
      QUAL: begin
        if (code == 2'b00) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (code == r_code) begin
          if (r_cnt >= CNT_LAST) begin
            w_state_nxt = ACCEPT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else begin
          // a different coin code restarts qualification on the new code
          w_code_nxt = code;
          w_cnt_nxt  = CNT_ONE;
        end
      end
      ACCEPT: begin
        w_state_nxt = WAIT_REL;
        w_cnt_nxt   = '0;
      end
      WAIT_REL: begin
        if (code == 2'b00) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_enter_accept = (w_state_nxt == ACCEPT);
  assign w_accept       = (r_state == ACCEPT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_coin_p <= 1'b0;
      r_coin_h <= 1'b0;
      r_coin_f <= 1'b0;
    end else begin
      r_coin_p <= w_enter_accept && (w_code_nxt == 2'b11);
      r_coin_h <= w_enter_accept && (w_code_nxt == 2'b10);
      r_coin_f <= w_enter_accept && (w_code_nxt == 2'b01);
    end
  end

  always_comb begin
    w_coin_val = '0;
    case (r_code)
      2'b11:   w_coin_val = (CREDIT_W + 1)'(4);
      2'b10:   w_coin_val = (CREDIT_W + 1)'(2);
      2'b01:   w_coin_val = (CREDIT_W + 1)'(1);
      default: w_coin_val = '0;
    endcase
  end

  // clear takes effect before the coin is added
  assign w_base = clear ? '0 : {1'b0, r_credit};
  assign w_sum  = w_base + w_coin_val;

  always_comb begin
    w_credit_nxt = r_credit;
    w_ovf_nxt    = r_ovf;
    if (w_accept) begin
      if (w_sum > MAX_EXT) begin
        w_credit_nxt = MAX_EXT[CREDIT_W-1:0];
        w_ovf_nxt    = 1'b1;
      end else begin
        w_credit_nxt = w_sum[CREDIT_W-1:0];
        w_ovf_nxt    = clear ? 1'b0 : r_ovf;
      end
    end else if (clear) begin
      w_credit_nxt = '0;
      w_ovf_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_credit <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_credit <= w_credit_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  assign coin_p     = r_coin_p;
  assign coin_h     = r_coin_h;
  assign coin_f     = r_coin_f;
  assign coin_valid = r_coin_p | r_coin_h | r_coin_f;
  assign credit     = r_credit;
  assign overflow   = r_ovf;

`ifdef COIN_TALLY_EN
  logic [7:0] r_tally_p, r_tally_h, r_tally_f;

  function automatic logic [7:0] tally_next(input logic [7:0] cur, input logic hit,
                                            input logic clr);
    logic [7:0] base;
    base = clr ? 8'd0 : cur;
    if (hit && (base != 8'hFF)) return base + 8'd1;
    return base;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tally_p <= 8'd0;
      r_tally_h <= 8'd0;
      r_tally_f <= 8'd0;
    end else begin
      r_tally_p <= tally_next(r_tally_p, w_accept && (r_code == 2'b11), clear);
      r_tally_h <= tally_next(r_tally_h, w_accept && (r_code == 2'b10), clear);
      r_tally_f <= tally_next(r_tally_f, w_accept && (r_code == 2'b01), clear);
    end
  end

  assign tally_p = r_tally_p;
  assign tally_h = r_tally_h;
  assign tally_f = r_tally_f;
`endif

endmodule

// File: tb/tb_coin_decoder.sv
// Scoreboard bench for coin_decoder (default build, DEBOUNCE_CYC=3): stimulus queues expected coins,
// a negedge monitor matches each pulse and the credit/overflow seen one cycle later.
module tb_coin_decoder;

  logic       clk;
  logic       reset_n;
  logic [1:0] code;
  logic       clear;
  logic       coin_p, coin_h, coin_f, coin_valid;
  logic [7:0] credit;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  int m_credit = 0;
  logic m_ovf  = 1'b0;

  typedef struct packed {
    logic [2:0] pulses;
    logic [7:0] credit;
    logic       ovf;
  } exp_t;

  exp_t q[$];

  logic       chk_pending = 1'b0;
  logic [7:0] chk_credit;
  logic       chk_ovf;

  coin_decoder #(.CREDIT_W(8), .MAX_CREDIT(255), .DEBOUNCE_CYC(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .code      (code),
    .clear     (clear),
    .coin_p    (coin_p),
    .coin_h    (coin_h),
    .coin_f    (coin_f),
    .coin_valid(coin_valid),
    .credit    (credit),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_pending) begin
      chk("credit_after_coin", int'(credit), int'(chk_credit));
      chk("overflow_after_coin", int'(overflow), int'(chk_ovf));
      chk_pending = 1'b0;
    end
    if (coin_valid || coin_p || coin_h || coin_f) begin
      if (q.size() == 0) begin
        chk("spurious_pulse", int'({coin_p, coin_h, coin_f, coin_valid}), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_phf", int'({coin_p, coin_h, coin_f}), int'(e.pulses));
        chk("coin_valid", int'(coin_valid), 1);
        chk_credit  = e.credit;
        chk_ovf     = e.ovf;
        chk_pending = 1'b1;
      end
    end
  end

  task automatic hold(input logic [1:0] c, input int n);
    code = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_coin(input logic [1:0] c);
    int   v;
    exp_t e;
    v = (c == 2'b11) ? 4 : (c == 2'b10) ? 2 : 1;
    if (m_credit + v > 255) begin
      m_credit = 255;
      m_ovf    = 1'b1;
    end else begin
      m_credit = m_credit + v;
    end
    e.pulses = {c == 2'b11, c == 2'b10, c == 2'b01};
    e.credit = 8'(m_credit);
    e.ovf    = m_ovf;
    q.push_back(e);
  endtask

  task automatic insert(input logic [1:0] c);
    expect_coin(c);
    hold(c, 3);
    hold(2'b00, 2);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_credit = 0;
    m_ovf    = 1'b0;
    chk("credit_after_clear", int'(credit), 0);
    chk("overflow_after_clear", int'(overflow), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    code    = 2'b00;
    clear   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_credit", int'(credit), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_pulses", int'({coin_p, coin_h, coin_f, coin_valid}), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // penny held exactly the debounce length
    expect_coin(2'b11);
    hold(2'b11, 3);
    hold(2'b00, 3);
    chk("credit_t1", int'(credit), 4);

    // farthing too short: glitch, no pulse
    hold(2'b01, 2);
    hold(2'b00, 3);
    chk("credit_glitch", int'(credit), 4);

    // ha'penny one cycle then penny: only the penny counts
    expect_coin(2'b11);
    hold(2'b10, 1);
    hold(2'b11, 3);
    hold(2'b00, 3);
    chk("credit_relatch", int'(credit), 8);

    insert(2'b01);
    insert(2'b10);
    chk("credit_mixed", int'(credit), 11);

    // saturation: 252 + farthing = 253, + ha'penny = 255 exact, then clipped coins
    pulse_clear();
    for (int i = 0; i < 63; i++) insert(2'b11);
    insert(2'b01);
    chk("credit_253", int'(credit), 253);
    insert(2'b10);
    chk("exact_max_no_ovf", int'(overflow), 0);
    insert(2'b11);
    insert(2'b01);
    chk("credit_saturated", int'(credit), 255);
    chk("overflow_sticky", int'(overflow), 1);
    pulse_clear();

    // clear in the ACCEPT cycle of a ha'penny with credit 20
    for (int i = 0; i < 5; i++) insert(2'b11);
    chk("credit_20", int'(credit), 20);
    m_credit = 0;
    m_ovf    = 1'b0;
    expect_coin(2'b10);
    hold(2'b10, 3);
    clear = 1'b1;
    code  = 2'b00;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("credit_clear_accept", int'(credit), 2);

    // penny held 50 cycles counts once
    expect_coin(2'b11);
    hold(2'b11, 50);
    hold(2'b00, 2);
    chk("credit_long_hold", int'(credit), 6);

    // reset during QUAL: coin lost, then the still-present coin qualifies afresh
    hold(2'b11, 2);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midqual_reset_credit", int'(credit), 0);
    chk("midqual_reset_valid", int'(coin_valid), 0);
    m_credit = 0;
    m_ovf    = 1'b0;
    expect_coin(2'b11);
    reset_n = 1'b1;
    hold(2'b11, 3);
    hold(2'b00, 3);
    chk("credit_after_reset_coin", int'(credit), 4);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
